// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared constants and types for the pipelined fetch unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int INST_W         = 32;
    localparam int BYTES_PER_INST = 4;
    localparam int ADDR_W_DEFAULT = 32;

    localparam logic [ADDR_W_DEFAULT-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [ADDR_W_DEFAULT-1:0] pc;
        logic [INST_W-1:0]         inst;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_if
//  Description : Redirect, instruction-memory and decode handshake bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if #(
    parameter int ADDR_W    = 32,
    parameter int IM_AWIDTH = 10
);
    import fetch_pkg::*;

    logic                  redirect_valid;
    logic [ADDR_W-1:0]     redirect_pc;
    logic                  im_rd_en;
    logic [IM_AWIDTH-1:0]  im_addr;
    logic [INST_W-1:0]     im_rdata;
    logic                  inst_valid;
    logic                  inst_ready;
    logic [INST_W-1:0]     inst;
    logic [ADDR_W-1:0]     inst_pc;
    logic                  err_misalign;

    modport master (
        input  redirect_valid, redirect_pc, im_rdata, inst_ready,
        output im_rd_en, im_addr, inst_valid, inst, inst_pc, err_misalign
    );

    modport slave (
        output redirect_valid, redirect_pc, im_rdata, inst_ready,
        input  im_rd_en, im_addr, inst_valid, inst, inst_pc, err_misalign
    );

endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Synchronous prefetch FIFO; flush overrides push and pop.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int               DEPTH   = 4,
    parameter int               WIDTH   = 64,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    localparam int              PTR_W   = $clog2(DEPTH),
    localparam int              CNT_W   = PTR_W + 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_push,
    input  wire logic             i_pop,
    input  wire logic             i_flush,
    input  wire logic [WIDTH-1:0] i_wdata,
    output logic      [WIDTH-1:0] o_rdata,
    output logic      [CNT_W-1:0] o_count,
    output logic                  o_empty,
    output logic                  o_full
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_pop;

    assign w_do_pop = i_pop & ~o_empty;

    // Storage is reset too so the head reads a defined value while empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= RST_VAL;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(i_push) - CNT_W'(w_do_pop);
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_W'(DEPTH));

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Pipelined instruction fetcher with credit-based prefetch.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                IM_AWIDTH  = 10,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(RESET_PC_DEFAULT),
    parameter int                FIFO_DEPTH = 4
) (
    input  wire logic     clk,
    input  wire logic     rst,
    fetch_unit_if.master  bus
);

    localparam int ENT_W = ADDR_W + INST_W;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [ADDR_W-1:0] r_pc;
    logic              r_inflight;
    logic [ADDR_W-1:0] r_inflight_pc;
    logic              r_kill;
    logic              r_err;

    logic              w_pop;
    logic              w_push;
    logic              w_issue;
    logic [CNT_W:0]    w_credit;
    logic [CNT_W-1:0]  w_fifo_count;
    logic              w_fifo_empty;
    logic              w_fifo_full;
    logic [ENT_W-1:0]  w_head;
    logic [ADDR_W-1:0] w_redirect_aligned;

    assign w_pop              = ~w_fifo_empty & bus.inst_ready;
    assign w_push             = r_inflight & ~r_kill;
    assign w_redirect_aligned = {bus.redirect_pc[ADDR_W-1:2], 2'b00};

    // Entries that will occupy the FIFO once the current response lands
    assign w_credit = {1'b0, w_fifo_count} - (CNT_W+1)'(w_pop) + (CNT_W+1)'(r_inflight);
    assign w_issue  = ~rst & ~bus.redirect_valid & (w_credit < (CNT_W+1)'(FIFO_DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= RESET_PC;
            r_kill        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            r_kill     <= bus.redirect_valid & r_inflight;
            r_err      <= bus.redirect_valid & (|bus.redirect_pc[1:0]);
            if (bus.redirect_valid) begin
                r_pc <= w_redirect_aligned;
            end else if (w_issue) begin
                r_pc <= r_pc + ADDR_W'(BYTES_PER_INST);
            end
            if (w_issue) begin
                r_inflight_pc <= r_pc;
            end
        end
    end

    fetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .WIDTH   (ENT_W),
        .RST_VAL ({RESET_PC, {INST_W{1'b0}}})
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (bus.redirect_valid),
        .i_wdata ({r_inflight_pc, bus.im_rdata}),
        .o_rdata (w_head),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    assign bus.im_rd_en     = w_issue;
    assign bus.im_addr      = r_pc[IM_AWIDTH+1:2];
    assign bus.inst_valid   = ~w_fifo_empty;
    assign bus.inst         = w_head[INST_W-1:0];
    assign bus.inst_pc      = w_head[ENT_W-1:INST_W];
    assign bus.err_misalign = r_err;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_push && !w_pop && !bus.redirect_valid && w_fifo_full));

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit with an in-order PC model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errs;

    fetch_unit_if #(.ADDR_W(32), .IM_AWIDTH(10)) bus ();

    fetch_unit #(
        .ADDR_W     (32),
        .IM_AWIDTH  (10),
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] im_mem [1024];
    initial begin
        for (int i = 0; i < 1024; i++) im_mem[i] = 32'h1000_0000 + 32'(i);
    end

    always @(posedge clk) begin
        if (bus.im_rd_en) bus.im_rdata <= im_mem[bus.im_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return 32'h1000_0000 + {22'd0, pc[11:2]};
    endfunction

    // Reference model: decode must see an unbroken run of PCs from the last
    // reset/redirect target, each carrying the memory word at that PC.
    logic [31:0] m_exp_pc;
    logic        m_prev_mis;
    int          m_empty_run;

    always @(negedge clk) begin
        if (rst) begin
            m_exp_pc    = 32'h0;
            m_prev_mis  = 1'b0;
            m_empty_run = 0;
            chk("m_rst_valid", 32'(bus.inst_valid), 32'd0);
        end else begin
            chk("m_misalign", 32'(bus.err_misalign), 32'(m_prev_mis));
            if (bus.redirect_valid) begin
                m_exp_pc = {bus.redirect_pc[31:2], 2'b00};
            end else if (bus.inst_valid && bus.inst_ready) begin
                chk("m_pc", bus.inst_pc, m_exp_pc);
                chk("m_inst", bus.inst, word_of(m_exp_pc));
                m_exp_pc = m_exp_pc + 32'd4;
            end
            m_empty_run = bus.inst_valid ? 0 : m_empty_run + 1;
            if (bus.redirect_valid) m_empty_run = 0;
            chk("m_starve", 32'(m_empty_run <= 3), 32'd1);
            m_prev_mis = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
        end
    end

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    typedef struct {
        logic [31:0] rpc;
        logic [31:0] exp_pc;
        logic [9:0]  addr1;
        logic [9:0]  addr2;
        logic        mis;
    } vec_t;

    vec_t tv [5];

    initial begin
        #2_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int n_iss;
        n_checks = 0;
        n_errs   = 0;
        tv[0] = '{32'h0000_0200, 32'h0000_0200, 10'h080, 10'h081, 1'b0};
        tv[1] = '{32'h0000_0106, 32'h0000_0104, 10'h041, 10'h042, 1'b1};
        tv[2] = '{32'h0000_0FFC, 32'h0000_0FFC, 10'h3FF, 10'h000, 1'b0};
        tv[3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFC, 10'h3FF, 10'h000, 1'b1};
        tv[4] = '{32'h0000_0401, 32'h0000_0400, 10'h100, 10'h101, 1'b1};

        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.inst_ready     = 1'b1;
        repeat (2) adv();
        smp();
        chk("rst_rd_en", 32'(bus.im_rd_en), 32'd0);
        chk("rst_valid", 32'(bus.inst_valid), 32'd0);
        chk("rst_inst", bus.inst, 32'd0);
        chk("rst_inst_pc", bus.inst_pc, 32'd0);
        chk("rst_err", 32'(bus.err_misalign), 32'd0);

        // Reset release and fill
        adv(); rst = 1'b0;
        smp();
        chk("first_rd_en", 32'(bus.im_rd_en), 32'd1);
        chk("first_addr", 32'(bus.im_addr), 32'd0);
        adv(); smp();
        chk("fill_valid", 32'(bus.inst_valid), 32'd0);
        for (int k = 0; k < 6; k++) begin
            adv(); smp();
            chk("stream_valid", 32'(bus.inst_valid), 32'd1);
            chk("stream_pc", bus.inst_pc, 32'(k * 4));
            chk("stream_inst", bus.inst, 32'h1000_0000 + 32'(k));
        end

        // Stall: only FIFO_DEPTH fetches outstanding, then drain without gaps
        adv(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0; bus.inst_ready = 1'b0;
        smp();
        adv(); bus.redirect_valid = 1'b0;
        n_iss = 0;
        for (int k = 0; k < 10; k++) begin
            smp();
            if (bus.im_rd_en) n_iss++;
            adv();
        end
        chk("stall_issues", 32'(n_iss), 32'd4);
        smp();
        chk("stall_rd_en", 32'(bus.im_rd_en), 32'd0);
        chk("stall_head", bus.inst_pc, 32'h0);
        adv(); bus.inst_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            smp();
            chk("drain_valid", 32'(bus.inst_valid), 32'd1);
            chk("drain_pc", bus.inst_pc, 32'(k * 4));
            adv();
        end

        // Redirect table, each preceded by a partial stall so state is busy
        for (int i = 0; i < 5; i++) begin
            bus.inst_ready = 1'b0;
            repeat (3) adv();
            bus.redirect_valid = 1'b1; bus.redirect_pc = tv[i].rpc; bus.inst_ready = 1'b1;
            smp();
            chk("redir_no_issue", 32'(bus.im_rd_en), 32'd0);
            adv(); bus.redirect_valid = 1'b0;
            smp();
            chk("redir_err", 32'(bus.err_misalign), 32'(tv[i].mis));
            chk("redir_rd_en", 32'(bus.im_rd_en), 32'd1);
            chk("redir_addr1", 32'(bus.im_addr), 32'(tv[i].addr1));
            chk("redir_empty1", 32'(bus.inst_valid), 32'd0);
            adv(); smp();
            chk("redir_addr2", 32'(bus.im_addr), 32'(tv[i].addr2));
            chk("redir_err_once", 32'(bus.err_misalign), 32'd0);
            chk("redir_empty2", 32'(bus.inst_valid), 32'd0);
            adv(); smp();
            chk("redir_valid", 32'(bus.inst_valid), 32'd1);
            chk("redir_pc", bus.inst_pc, tv[i].exp_pc);
            chk("redir_inst", bus.inst, 32'h1000_0000 + 32'(tv[i].addr1));
        end

        // Redirect coinciding with a pop, superseded by a second redirect
        adv(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0300;
        smp();
        adv(); bus.redirect_pc = 32'h0000_0040;
        smp();
        adv(); bus.redirect_valid = 1'b0;
        smp();
        chk("dbl_empty", 32'(bus.inst_valid), 32'd0);
        adv(); adv(); smp();
        chk("dbl_valid", 32'(bus.inst_valid), 32'd1);
        chk("dbl_pc", bus.inst_pc, 32'h0000_0040);
        repeat (4) adv();

        // Asynchronous reset mid-stream
        smp();
        chk("pre_rst_valid", 32'(bus.inst_valid), 32'd1);
        adv(); rst = 1'b1;
        #1;
        chk("arst_valid", 32'(bus.inst_valid), 32'd0);
        chk("arst_inst", bus.inst, 32'd0);
        chk("arst_pc", bus.inst_pc, 32'd0);
        chk("arst_rd_en", 32'(bus.im_rd_en), 32'd0);
        smp();
        adv(); rst = 1'b0;
        smp();
        chk("rel_rd_en", 32'(bus.im_rd_en), 32'd1);
        chk("rel_addr", 32'(bus.im_addr), 32'd0);
        adv(); adv(); smp();
        chk("rel_pc", bus.inst_pc, 32'd0);

        // Randomised traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            adv();
            bus.inst_ready = ($urandom_range(3) != 0);
            if ($urandom_range(15) == 0) begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = ($urandom_range(1) == 0) ? $urandom : ($urandom & 32'h0000_1FFF);
            end else begin
                bus.redirect_valid = 1'b0;
            end
        end
        adv(); bus.redirect_valid = 1'b0; bus.inst_ready = 1'b1;
        repeat (8) adv();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised, pipelined successor of the single-cycle instruction fetcher, for the multi-cycle/pipelined datapath.
- Owns the PC and drives a synchronous-read instruction memory with 1-cycle read latency.
- Buffers fetched instructions in a prefetch FIFO and presents them to decode over a valid/ready handshake.
- Accepts a redirect from execute for taken branches and jumps; a redirect flushes all queued and in-flight fetches.

Parameters:
ADDR_W, 32, PC width in bits.
IM_AWIDTH, 10, instruction-memory word-address width (1024 words).
RESET_PC, 32'h0000_0000, PC value after reset; bits [1:0] must be 0.
FIFO_DEPTH, 4, prefetch FIFO entries; power of two, minimum 2.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
redirect_valid  input  1  redirect the PC this cycle.
redirect_pc  input  ADDR_W  new fetch address.
im_rd_en  output  1  instruction-memory read strobe.
im_addr  output  IM_AWIDTH  word address, equal to pc_q[IM_AWIDTH+1:2].
im_rdata  input  32  read data, valid the cycle after im_rd_en.
inst_valid  output  1  FIFO head is valid.
inst_ready  input  1  decode accepts the head.
inst  output  32  head instruction.
inst_pc  output  ADDR_W  PC of the head instruction.
err_misalign  output  1  one-cycle pulse when redirect_pc[1:0] is nonzero.

Behaviour:
- One clock domain, clk. rst is asynchronous and active-high.
- Reset values:
  - pc_q=RESET_PC, FIFO empty, inflight_q=0, kill_q=0.
  - inst_valid=0, inst=0, inst_pc=RESET_PC, err_misalign=0.
  - im_rd_en=0 while rst is high.
  - Reset asserted mid-operation discards everything, with no partial pushes.
- Issue condition: issue = !rst & !redirect_valid & (count - pop + inflight_q < FIFO_DEPTH), where pop = inst_valid & inst_ready.
- On issue:
  - im_rd_en=1, im_addr taken from pc_q.
  - At the clock edge: pc_q += 4 (mod 2^ADDR_W), inflight_q=1, inflight_pc=pc_q.
  - With no issue, inflight_q=0.
- Response: the cycle after an issue, im_rdata and inflight_pc are pushed into the FIFO at the clock edge, unless kill_q=1.
  - Credit accounting guarantees the FIFO never overflows; overflow is an assertion failure.
- Output: inst, inst_pc and inst_valid come from registered FIFO storage. An entry pushed at edge E is visible in the cycle after E; there is no bypass.
- Pop: valid & ready removes the head at the edge. Push and pop in the same cycle leave count unchanged.
- Redirect in cycle N:
  - No issue in cycle N.
  - At the edge: pc_q = {redirect_pc[ADDR_W-1:2],2'b00}, FIFO cleared, kill_q = inflight_q.
  - Cycle N+1: a response arriving from a cycle-N-1 issue is dropped; kill_q clears. First issue at the new PC happens in N+1.
  - Push at the end of N+2; inst_valid=1 in N+3. Redirect-to-valid latency is 3 cycles with decode ready.
- Redirect plus pop in the same cycle: the redirect wins. The popped head counts as flushed; no other state is affected.
- Back-to-back redirects: each redirect supersedes the previous one; only the last redirect_pc is fetched.
- Misaligned redirect: low bits are cleared as above; err_misalign=1 in cycle N+1 only.
- Steady state with ready held high: one instruction per cycle after a 2-cycle fill.
- Stall with ready low: issue stops once count + inflight reaches FIFO_DEPTH; pc_q holds; no instruction is lost or duplicated.
- Wrap-around: pc_q wraps at 2^ADDR_W. im_addr wraps naturally within 2^IM_AWIDTH words.

Decomposition:
- Shared package fetch_pkg:
  - INST_W=32, BYTES_PER_INST=4.
  - Entry typedef {pc[ADDR_W-1:0], inst[31:0]}.
  - RESET_PC default constant.
- Sub-module fetch_fifo (parametrised DEPTH and WIDTH):
  - Synchronous FIFO with push, pop, flush, count, empty and full.
  - flush has priority over push and pop in the same cycle.
- The top level holds pc_q, the in-flight/kill tracking and the credit logic.

Test Plan:
- Reset release, ready=1, IM loaded with word i = 0x1000_0000+i -> first im_rd_en in cycle 1; inst_valid from cycle 3; inst_pc 0x0,0x4,0x8... with inst 0x1000_0000,0x1000_0001... one per cycle.
- ready=0 for 10 cycles after fill (FIFO_DEPTH=4) -> at most 4 issues outstanding; im_rd_en low afterwards; pc_q=0x10; on ready=1, PCs 0x0..0xC are delivered in order, then 0x10 with no gap or duplicate.
- redirect_valid with redirect_pc=0x0000_0200 while FIFO is full and a read is in flight -> FIFO flushed, stale response dropped; next im_addr=0x80; inst_valid=1 with inst_pc=0x200 exactly 3 cycles later.
- Redirect in the same cycle as valid&ready, then a second redirect to 0x40 the next cycle -> only PCs from 0x40 onward appear.
- redirect_pc=0x0000_0106 -> err_misalign pulses once; fetch resumes at 0x104.
- rst asserted mid-stream for 1 cycle asynchronously -> outputs return to reset values immediately; fetch restarts at RESET_PC; IM_AWIDTH wrap: pc 0xFFC -> 0x1000 gives im_addr 0x3FF -> 0x000.
